// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a camera register-init table held in ROM and issues one
// 3-byte SCCB register write per entry through the byte-level master.
module sccb_init_seq #(
    parameter int         CLK_FREQ   = 25_000_000,
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter int         ROM_AW     = 8,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_CYCLES = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              m_start,
    output logic              m_stop,
    output logic [7:0]        m_wr_data,
    input  logic [1:0]        m_ack,
    input  logic [3:0]        m_state,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ROM_AW-1:0] err_index
);
    // state     | meaning
    // IDLE      | waiting for go
    // FETCH     | ROM read latency
    // DECODE    | classify entry: write, delay or end marker
    // START     | issue start + device address once master is idle
    // XFER      | stream register address and value bytes
    // WAIT_IDLE | stop issued, wait for master to return idle
    // GAP       | inter-transaction idle time, then advance or retry
    // DELAY     | millisecond delay entry
    // FIN       | publish done and return to IDLE
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, START, XFER, WAIT_IDLE, GAP, DELAY, FIN
    } state_t;

    localparam int CYC_MS  = CLK_FREQ / 1000;
    localparam int TMR_MAX = (CYC_MS > GAP_CYCLES) ? CYC_MS : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 2);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] MS_LOAD  = TMR_W'(CYC_MS - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [7:0]       DEV_WR   = {DEV_ADDR, 1'b0};

    state_t            state_q, state_d;
    logic [23:0]       entry_q, entry_d;
    logic [2:0]        bidx_q, bidx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              nack_q, nack_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        ms_q, ms_d;
    logic [ROM_AW-1:0] rom_addr_d, err_index_d;
    logic              busy_d, done_d, err_d;
    logic              adv;
    logic              last_entry;

    assign last_entry = (rom_addr == {ROM_AW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            entry_q   <= '0;
            bidx_q    <= '0;
            retry_q   <= '0;
            nack_q    <= 1'b0;
            tmr_q     <= '0;
            ms_q      <= '0;
            rom_addr  <= '0;
            err_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            bidx_q    <= bidx_d;
            retry_q   <= retry_d;
            nack_q    <= nack_d;
            tmr_q     <= tmr_d;
            ms_q      <= ms_d;
            rom_addr  <= rom_addr_d;
            err_index <= err_index_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        bidx_d      = bidx_q;
        retry_d     = retry_q;
        nack_d      = nack_q;
        tmr_d       = tmr_q;
        ms_d        = ms_q;
        rom_addr_d  = rom_addr;
        err_index_d = err_index;
        busy_d      = busy;
        done_d      = done;
        err_d       = err;
        m_start     = 1'b0;
        m_stop      = 1'b0;
        m_wr_data   = DEV_WR;
        adv         = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    rom_addr_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                entry_d = rom_data;
                if (rom_data == 24'hFFFFFF) begin
                    state_d = FIN;
                end else if (rom_data[23:8] == 16'hFFFE) begin
                    if (rom_data[7:0] == 8'd0) begin
                        adv = 1'b1;
                    end else begin
                        tmr_d   = MS_LOAD;
                        ms_d    = rom_data[7:0];
                        state_d = DELAY;
                    end
                end else begin
                    bidx_d  = 3'd0;
                    retry_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (m_state == 4'd0) begin
                    m_start = 1'b1;
                    bidx_d  = 3'd1;
                    state_d = XFER;
                end
            end
            XFER: begin
                // Next byte must be on the bus before the tick that latches it.
                case (bidx_q)
                    3'd1:    m_wr_data = entry_q[23:16];
                    3'd2:    m_wr_data = entry_q[15:8];
                    default: m_wr_data = entry_q[7:0];
                endcase
                if (m_ack[1]) begin
                    if (!m_ack[0]) begin
                        m_stop  = 1'b1;
                        nack_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end else if (bidx_q == 3'd4) begin
                        m_stop  = 1'b1;
                        nack_d  = 1'b0;
                        state_d = WAIT_IDLE;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (m_state == 4'd0) begin
                    tmr_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (!nack_q) begin
                    adv = 1'b1;
                end else if (retry_q < RTY_MAX) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = START;
                end else begin
                    err_d       = 1'b1;
                    err_index_d = rom_addr;
                    state_d     = FIN;
                end
            end
            DELAY: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (ms_q != 8'd1) begin
                    ms_d  = ms_q - 8'd1;
                    tmr_d = MS_LOAD;
                end else begin
                    adv = 1'b1;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Running off the end of the table without an end marker is an abort.
        if (adv) begin
            if (last_entry) begin
                err_d       = 1'b1;
                err_index_d = rom_addr;
                state_d     = FIN;
            end else begin
                rom_addr_d = rom_addr + ROM_AW'(1);
                state_d    = FETCH;
            end
        end
    end
endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: ROM model, behavioural byte-level SCCB master with
// configurable slave ACK policy, and a byte-stream scoreboard.
module tb_sccb_init_seq;
    localparam int         CLK_FREQ   = 1_000_000;
    localparam int         CYC_MS     = CLK_FREQ / 1000;
    localparam int         ROM_AW     = 2;
    localparam int         MAX_RETRY  = 3;
    localparam int         GAP_CYCLES = 20;
    localparam logic [7:0] DEV_WR     = 8'h78;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic [ROM_AW-1:0] rom_addr;
    logic [23:0]       rom_data;
    logic              m_start;
    logic              m_stop;
    logic [7:0]        m_wr_data;
    logic [1:0]        m_ack;
    logic [3:0]        m_state;
    logic              busy;
    logic              done;
    logic              err;
    logic [ROM_AW-1:0] err_index;

    logic [23:0] rom [4];
    logic [7:0]  exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_starts = 0;
    int ticks    = 0;
    int n_nacks  = 0;
    int t_stop_last = 0;
    int last_gap    = 0;
    int slave_mode  = 0;
    int nack_budget = 0;

    sccb_init_seq #(
        .CLK_FREQ  (CLK_FREQ),
        .DEV_ADDR  (7'h3C),
        .ROM_AW    (ROM_AW),
        .MAX_RETRY (MAX_RETRY),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .m_start  (m_start),
        .m_stop   (m_stop),
        .m_wr_data(m_wr_data),
        .m_ack    (m_ack),
        .m_state  (m_state),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_index(err_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic score_byte(input logic [7:0] b);
        if (exp_q.size() == 0) chk("byte_unexpected", 32'(b), 32'hFFFF_FFFF);
        else chk("byte_stream", 32'(b), 32'(exp_q.pop_front()));
    endtask

    task automatic push_write(input logic [23:0] e, input int nbytes);
        logic [7:0] bytes [4];
        bytes[0] = DEV_WR;
        bytes[1] = e[23:16];
        bytes[2] = e[15:8];
        bytes[3] = e[7:0];
        for (int i = 0; i < nbytes; i++) exp_q.push_back(bytes[i]);
    endtask

    // One transaction of the byte-level master; bails out if rst arrives.
    task automatic master_xfer();
        logic ackb;
        logic stp;
        @(posedge clk);
        #1 m_state = 4'd1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                if (rst) begin
                    #1 m_state = 4'd0;
                    m_ack = 2'b00;
                    return;
                end
            end
            #1;
            case (slave_mode)
                1:       ackb = !(i == 2 && n_nacks < nack_budget);
                2:       ackb = (i != 0);
                default: ackb = 1'b1;
            endcase
            if (!ackb) n_nacks++;
            m_ack = {1'b1, ackb};
            @(negedge clk);
            stp = m_stop;
            if (!ackb || i == 3) begin
                chk("stop_on_last_or_nack_tick", 32'(stp), 32'd1);
            end else begin
                chk("no_stop_on_mid_tick", 32'(stp), 32'd0);
                score_byte(m_wr_data);
            end
            if (stp) t_stop_last = cyc;
            @(posedge clk);
            #1 m_ack = 2'b00;
            ticks++;
            if (stp) break;
        end
        repeat (2) @(posedge clk);
        #1 m_state = 4'd0;
    endtask

    initial begin
        m_state = 4'd0;
        m_ack   = 2'b00;
        forever begin
            @(negedge clk);
            if (m_start === 1'b1 && rst === 1'b0) begin
                n_starts++;
                last_gap = cyc - t_stop_last;
                score_byte(m_wr_data);
                master_xfer();
            end
        end
    end

    task automatic run_seq(input bit spam);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) break;
            if (spam && busy && (i % 97 == 13)) begin
                go = 1'b1;
                @(negedge clk);
                go = 1'b0;
            end
        end
        chk("seq_done", 32'(done), 32'd1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int t0;
        int b0;
        int d1;
        int d6;
        rst = 1'b1;
        go  = 1'b1;
        rom[0] = 24'hFFFFFF; rom[1] = 24'hFFFFFF; rom[2] = 24'hFFFFFF; rom[3] = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_stop", 32'(m_stop), 32'd0);
        chk("rst_m_wr_data", 32'(m_wr_data), 32'(DEV_WR));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_index", 32'(err_index), 32'd0);
        rst = 1'b0;
        go  = 1'b0;
        @(negedge clk);
        chk("go_with_rst_ignored", 32'(busy), 32'd0);

        // Two writes separated by a 5 ms delay entry.
        rom[0] = 24'h300882; rom[1] = 24'hFFFE05; rom[2] = 24'h310303; rom[3] = 24'hFFFFFF;
        exp_q.delete();
        push_write(rom[0], 4);
        push_write(rom[2], 4);
        slave_mode = 0;
        s0 = n_starts;
        run_seq(1'b0);
        d1 = last_gap;
        chk("t1_starts", 32'(n_starts - s0), 32'd2);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_stream_left", 32'(exp_q.size()), 32'd0);
        chk("t1_delay_min", 32'(d1 >= 5 * CYC_MS), 32'd1);

        // NACK on byte 2 twice, then success.
        rom[0] = 24'h300882; rom[1] = 24'hFFFFFF; rom[2] = 24'hFFFFFF; rom[3] = 24'hFFFFFF;
        exp_q.delete();
        push_write(rom[0], 3);
        push_write(rom[0], 3);
        push_write(rom[0], 4);
        slave_mode  = 1;
        b0          = n_nacks;
        nack_budget = n_nacks + 2;
        s0 = n_starts;
        run_seq(1'b0);
        chk("t2_starts", 32'(n_starts - s0), 32'd3);
        chk("t2_nacks", 32'(n_nacks - b0), 32'd2);
        chk("t2_err", 32'(err), 32'd0);
        chk("t2_stream_left", 32'(exp_q.size()), 32'd0);

        // Device address always NACKed: retries exhausted.
        exp_q.delete();
        for (int i = 0; i < 1 + MAX_RETRY; i++) push_write(rom[0], 1);
        slave_mode = 2;
        s0 = n_starts;
        run_seq(1'b0);
        chk("t3_starts", 32'(n_starts - s0), 32'(1 + MAX_RETRY));
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_err_index", 32'(err_index), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        repeat (200) @(negedge clk);
        chk("t3_no_more_start", 32'(n_starts - s0), 32'(1 + MAX_RETRY));
        chk("t3_stream_left", 32'(exp_q.size()), 32'd0);

        // No end marker: table runs off its last entry.
        rom[0] = 24'h300101; rom[1] = 24'h300202; rom[2] = 24'h300303; rom[3] = 24'h300404;
        exp_q.delete();
        for (int i = 0; i < 4; i++) push_write(rom[i], 4);
        slave_mode = 0;
        s0 = n_starts;
        run_seq(1'b0);
        chk("t4_starts", 32'(n_starts - s0), 32'd4);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_err_index", 32'(err_index), 32'd3);
        chk("t4_stream_left", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a write, after the device address is ACKed.
        rom[0] = 24'h300882; rom[1] = 24'hFFFE00; rom[2] = 24'h310303; rom[3] = 24'hFFFFFF;
        exp_q.delete();
        push_write(rom[0], 4);
        t0 = ticks;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ticks - t0 >= 1) break;
        end
        chk("t5_reached_byte1", 32'(ticks - t0), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_rom_addr", 32'(rom_addr), 32'd0);
        chk("t5_m_start", 32'(m_start), 32'd0);
        chk("t5_m_stop", 32'(m_stop), 32'd0);
        chk("t5_m_wr_data", 32'(m_wr_data), 32'(DEV_WR));
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_err", 32'(err), 32'd0);

        // Restart from entry 0 with go spammed while busy; zero delay is skipped.
        exp_q.delete();
        push_write(rom[0], 4);
        push_write(rom[2], 4);
        s0 = n_starts;
        run_seq(1'b1);
        d6 = last_gap;
        chk("t6_starts", 32'(n_starts - s0), 32'd2);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_stream_left", 32'(exp_q.size()), 32'd0);
        chk("t6_zero_delay_skip", 32'(d6), 32'(d1 - 5 * CYC_MS));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sccb_init_seq.md
Name: sccb_init_seq

Overview:
- Sequences the existing SCCB/I2C byte-level master through a camera register-initialisation table held in an external synchronous ROM.
- Fetches each table entry and drives the master's start/stop/wr_data handshake to issue one write of 2 address bytes plus 1 data byte.
- Handles delay and end markers in the table, retries NACKed writes, and reports done/error to the top-level camera bring-up logic.

Parameters:
- CLK_FREQ, 25_000_000, system clock in Hz; sets the cycles-per-millisecond delay count (CLK_FREQ/1000).
- DEV_ADDR, 7'h3C, 7-bit camera SCCB device address; byte 0 of each write is {DEV_ADDR,1'b0}.
- ROM_AW, 8, ROM address width; the table holds at most 2^ROM_AW entries.
- MAX_RETRY, 3, NACK retries per entry before aborting.
- GAP_CYCLES, 250, idle cycles enforced between transactions (10 us at 25 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- go  in  1  pulse; starts the sequence from entry 0; ignored while busy
- rom_addr  out  ROM_AW  table address; ROM returns data 1 cycle later
- rom_data  in  24  {reg_addr[15:0], value[7:0]}
- m_start  out  1  to master start
- m_stop  out  1  to master stop; combinational
- m_wr_data  out  8  to master wr_data; combinational byte mux
- m_ack  in  2  from master ack ([1]=tick, [0]=ACK)
- m_state  in  4  from master state; 0 = idle
- busy  out  1  sequence in progress
- done  out  1  sticky; sequence finished (success or abort)
- err  out  1  sticky; abort by retry exhaustion or missing end marker
- err_index  out  ROM_AW  entry index at abort

Behaviour:
- Reset values: rom_addr=0, m_start=0, m_stop=0, m_wr_data={DEV_ADDR,0}, busy=0, done=0, err=0, err_index=0. All internal counters clear. Reset mid-transaction leaves the master to its own reset; it is the same rst net.
- FSM states: IDLE, FETCH, DECODE, START, XFER, WAIT_IDLE, GAP, DELAY, FIN.
- IDLE: on go, set busy=1, clear done/err, rom_addr=0, go to FETCH.
- FETCH: wait 1 cycle for ROM latency, then go to DECODE.
- DECODE: latch rom_data.
  - 24'hFFFFFF: end marker; go to FIN.
  - rom_data[23:8]==16'hFFFE: delay of value ms; if value==0, skip; otherwise go to DELAY.
  - Anything else: clear the byte index (bidx=0) and the retry counter, go to START.
- START: only when m_state==0, assert m_start for exactly 1 cycle with m_wr_data={DEV_ADDR,0}. Set bidx=1, go to XFER.
- XFER:
  - m_wr_data mux: bidx 1 gives reg_addr[15:8], 2 gives reg_addr[7:0], 3 gives value. It is valid before every ack tick, because the master latches it on that tick.
  - On m_ack[1]&m_ack[0] with bidx<4: bidx++.
  - On m_ack[1]&m_ack[0] with bidx==4: m_stop=1 in that same cycle (combinational), go to WAIT_IDLE marked OK.
  - On m_ack[1]&!m_ack[0] (NACK) at any byte: m_stop=1 in that same cycle, go to WAIT_IDLE marked NACK.
  - m_stop is 0 in every other cycle.
- WAIT_IDLE: wait for m_state==0, then enter GAP and count GAP_CYCLES. At the end of GAP:
  - OK: rom_addr++, go to FETCH. If rom_addr was 2^ROM_AW-1 (no end marker seen), set err, err_index=rom_addr, go to FIN.
  - NACK with retry<MAX_RETRY: retry++, go to START for the same entry.
  - NACK with retries exhausted: set err, err_index=rom_addr, go to FIN.
- DELAY:
  - Count value×(CLK_FREQ/1000) cycles.
  - Use a 1-ms prescaler plus an 8-bit ms counter; no multiplier.
  - Then rom_addr++ and go to FETCH, with the same wrap rule as GAP.
- FIN: busy=0, done=1 (sticky until the next go or rst), return to IDLE.
- go during busy is ignored. go in the same cycle as rst: rst wins.

Test Plan:
- Table {0x3008_82, 0xFFFE_05, 0x3103_03, 0xFFFFFF}, slave model always ACKs.
  - Required: exactly 2 transactions with byte streams 78,30,08,82 and 78,31,03,03.
  - Required: ≥5×25_000 cycles between the first stop and the second start.
  - Required: done=1, err=0, busy=0.
- Slave NACKs byte 2 of entry 0 twice, then ACKs. Required: 3 starts for entry 0, m_stop asserted in the NACK-tick cycles, final done=1, err=0.
- Slave always NACKs the device address. Required: 1+MAX_RETRY=4 starts, then err=1, err_index=0, done=1, no further m_start.
- Table with no end marker, ROM_AW=2, all ACK. Required: 4 writes, then err=1, err_index=3.
- Assert rst during XFER (bidx=2). Required: next cycle all outputs at reset values; a following go restarts from entry 0.
- go pulses while busy, and a delay entry with value=0. Required: go has no effect; the delay entry adds no DELAY cycles (FETCH of the next entry follows DECODE immediately).
